// File: rtl/lns_add_prep.sv
// rtl/lns_add_prep.sv - LNS adder front end: operand compare, |La-Lb|, sign/zero classification
// Optional: LNS_PREP_SAT_EN saturates an out-of-range difference instead of truncating it.
`ifndef WBITS
`define WBITS 16
`endif
`ifndef FRACBITS
`define FRACBITS 8
`endif

module lns_add_prep #(
  parameter int WBITS    = `WBITS,
  parameter int FRACBITS = `FRACBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_sign,
  input  logic             a_zero,
  input  logic [WBITS-1:0] a_log,
  input  logic             b_sign,
  input  logic             b_zero,
  input  logic [WBITS-1:0] b_log,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WBITS-1:0] max_log,
  output logic [WBITS-1:0] diff,
  output logic             same_sign,
  output logic             res_sign,
  output logic             bypass,
  output logic             res_zero
);

  if (FRACBITS < 0 || FRACBITS >= WBITS) begin : g_bad_cfg
    $error("lns_add_prep: FRACBITS must lie in [0, WBITS)");
  end

  logic             r_s1_v;
  logic [WBITS:0]   r_s1_sub;
  logic             r_s1_a_ge_b;
  logic             r_s1_a_sign;
  logic             r_s1_b_sign;
  logic             r_s1_a_zero;
  logic             r_s1_b_zero;
  logic [WBITS-1:0] r_s1_a_log;
  logic [WBITS-1:0] r_s1_b_log;

  logic             r_s2_v;
  logic [WBITS-1:0] r_max_log;
  logic [WBITS-1:0] r_diff;
  logic             r_same_sign;
  logic             r_res_sign;
  logic             r_bypass;
  logic             r_res_zero;

  logic             w_s1_load;
  logic             w_s2_load;
  logic [WBITS:0]   w_sub;
  logic [WBITS:0]   w_mag;
  logic             w_ovf;
  logic [WBITS-1:0] w_diff_fit;
  logic [WBITS-1:0] w_max_log;
  logic [WBITS-1:0] w_diff;
  logic             w_res_sign;
  logic             w_bypass;
  logic             w_res_zero;

  // A stage loads when empty or when its content leaves this cycle.
  assign w_s2_load = !r_s2_v || out_ready;
  assign w_s1_load = !r_s1_v || w_s2_load;
  assign in_ready  = w_s1_load;

  // Sign-extend by one bit so the subtraction can never wrap.
  assign w_sub = {a_log[WBITS-1], a_log} - {b_log[WBITS-1], b_log};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v      <= 1'b0;
      r_s1_sub    <= '0;
      r_s1_a_ge_b <= 1'b0;
      r_s1_a_sign <= 1'b0;
      r_s1_b_sign <= 1'b0;
      r_s1_a_zero <= 1'b0;
      r_s1_b_zero <= 1'b0;
      r_s1_a_log  <= '0;
      r_s1_b_log  <= '0;
    end else if (w_s1_load) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_sub    <= w_sub;
        r_s1_a_ge_b <= !w_sub[WBITS];
        r_s1_a_sign <= a_sign;
        r_s1_b_sign <= b_sign;
        r_s1_a_zero <= a_zero;
        r_s1_b_zero <= b_zero;
        r_s1_a_log  <= a_log;
        r_s1_b_log  <= b_log;
      end
    end
  end

  assign w_mag = r_s1_sub[WBITS] ? (~r_s1_sub + 1'b1) : r_s1_sub;
  assign w_ovf = |w_mag[WBITS:WBITS-1];

`ifdef LNS_PREP_SAT_EN
  assign w_diff_fit = w_ovf ? {1'b0, {(WBITS-1){1'b1}}} : w_mag[WBITS-1:0];
`else
  assign w_diff_fit = w_mag[WBITS-1:0];
`endif

  always_comb begin
    w_max_log  = r_s1_a_ge_b ? r_s1_a_log : r_s1_b_log;
    w_res_sign = r_s1_a_ge_b ? r_s1_a_sign : r_s1_b_sign;
    w_diff     = w_diff_fit;
    w_bypass   = 1'b0;
    w_res_zero = 1'b0;
    if (r_s1_a_zero && r_s1_b_zero) begin
      w_max_log  = '0;
      w_res_sign = 1'b0;
      w_diff     = '0;
      w_res_zero = 1'b1;
    end else if (r_s1_a_zero) begin
      w_max_log  = r_s1_b_log;
      w_res_sign = r_s1_b_sign;
      w_diff     = '0;
      w_bypass   = 1'b1;
    end else if (r_s1_b_zero) begin
      w_max_log  = r_s1_a_log;
      w_res_sign = r_s1_a_sign;
      w_diff     = '0;
      w_bypass   = 1'b1;
    end else begin
      w_res_zero = (r_s1_a_sign != r_s1_b_sign) && (r_s1_sub == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v      <= 1'b0;
      r_max_log   <= '0;
      r_diff      <= '0;
      r_same_sign <= 1'b0;
      r_res_sign  <= 1'b0;
      r_bypass    <= 1'b0;
      r_res_zero  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_max_log   <= w_max_log;
        r_diff      <= w_diff;
        r_same_sign <= (r_s1_a_sign == r_s1_b_sign);
        r_res_sign  <= w_res_sign;
        r_bypass    <= w_bypass;
        r_res_zero  <= w_res_zero;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign max_log   = r_max_log;
  assign diff      = r_diff;
  assign same_sign = r_same_sign;
  assign res_sign  = r_res_sign;
  assign bypass    = r_bypass;
  assign res_zero  = r_res_zero;

`ifndef LNS_PREP_SAT_EN
`ifndef SYNTHESIS
  // Without saturation a difference beyond WBITS-1 magnitude bits would truncate silently.
  a_diff_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (r_s1_v && w_s2_load && !r_s1_a_zero && !r_s1_b_zero) |-> !w_ovf);
`endif
`endif

endmodule

// File: tb/tb_lns_add_prep.sv
// tb/tb_lns_add_prep.sv - directed-vector bench for lns_add_prep (WBITS=16, FRACBITS=8)
// Covers latency, classification, streaming with stall, async reset; saturation when LNS_PREP_SAT_EN.
module tb_lns_add_prep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        a_sign, a_zero, b_sign, b_zero;
  logic [15:0] a_log, b_log, max_log, diff;
  logic        same_sign, res_sign, bypass, res_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lns_add_prep dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .a_zero(a_zero), .a_log(a_log),
    .b_sign(b_sign), .b_zero(b_zero), .b_log(b_log),
    .out_valid(out_valid), .out_ready(out_ready),
    .max_log(max_log), .diff(diff), .same_sign(same_sign),
    .res_sign(res_sign), .bypass(bypass), .res_zero(res_zero)
  );

  // Input pack {a_sign,a_zero,a_log,b_sign,b_zero,b_log}; expected {max_log,diff,same,res_sign,bypass,res_zero}
  logic [35:0] vin [8] = '{
    {1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 16'h0100},
    {1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0480},
    {1'b0, 1'b0, 16'h0200, 1'b1, 1'b0, 16'h0200},
    {1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0500},
    {1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000},
    {1'b0, 1'b0, 16'hFF00, 1'b1, 1'b0, 16'h0100},
    {1'b1, 1'b0, 16'h0700, 1'b1, 1'b1, 16'h0000},
    {1'b1, 1'b0, 16'hC000, 1'b1, 1'b0, 16'hC000}
  };
  logic [35:0] vexp [8] = '{
    {16'h0300, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0},
    {16'h0480, 16'h0380, 1'b0, 1'b0, 1'b0, 1'b0},
    {16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1},
    {16'h0500, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0},
    {16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1},
    {16'h0100, 16'h0200, 1'b0, 1'b1, 1'b0, 1'b0},
    {16'h0700, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0},
    {16'hC000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {max_log, diff, same_sign, res_sign, bypass, res_zero};
  endfunction

  task automatic set_in(input logic [35:0] v, input logic vld);
    {a_sign, a_zero, a_log, b_sign, b_zero, b_log} = v;
    in_valid = vld;
  endtask

  task automatic run_vec(input string tag, input logic [35:0] v, input logic [35:0] e);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    set_in(v, 1'b1);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
    end while (!out_valid && lat < 10);
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check(tag, 64'(outs()), 64'(e));
  endtask

  task automatic run_stream();
    int          in_idx = 0;
    int          out_idx = 0;
    int          cyc = 0;
    logic        saw_block = 1'b0;
    logic        held = 1'b0;
    logic [36:0] hold_val = '0;
    while (out_idx < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (in_idx < 8) set_in(vin[in_idx], 1'b1);
      else in_valid = 1'b0;
      #1;
      if (held) check("stall_hold", 64'({out_valid, outs()}), 64'(hold_val));
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) in_idx++;
      if (out_valid && out_ready) begin
        check($sformatf("stream%0d", out_idx), 64'(outs()), 64'(vexp[out_idx]));
        out_idx++;
      end
      held     = out_valid && !out_ready;
      hold_val = {out_valid, outs()};
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", 64'(out_idx), 64'd8);
    check("in_ready_drop", 64'(saw_block), 64'd1);
  endtask

  task automatic run_reset();
    @(negedge clk);
    out_ready = 1'b0;
    set_in(vin[0], 1'b1);
    @(negedge clk);
    set_in(vin[1], 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    check("arst_data", 64'(outs()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("post_rst_idle", 64'(out_valid), 64'd0);
    run_vec("post_rst", vin[2], vexp[2]);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_in('0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'(outs()), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vin[i], vexp[i]);
    run_stream();
`ifdef LNS_PREP_SAT_EN
    run_vec("sat", {1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b0, 16'h8000},
                   {16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0});
`endif
    run_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
